// File: rtl/_ram.sv
`default_nettype none
// ============================================================================
//  Module      : _ram
//  Description : Parametrised word-addressable RAM. One synchronous write
//                port, two asynchronous read ports (A shares the write
//                address, B has its own address). Synchronous active-high
//                reset clears every word and wins over a coincident write.
//  Revision    : 1.0 - initial release
// ============================================================================
module _ram #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [ADDR_WIDTH-1:0] address_b,
  output logic [WIDTH-1:0]      out,
  output logic [WIDTH-1:0]      out_b
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  // One-hot decodes: w_sel drives both the write enable and read port A,
  // w_sel_b drives read port B.
  logic [c_DEPTH-1:0] w_sel;
  logic [c_DEPTH-1:0] w_sel_b;

  // Per-word gated contributions to each read port's AND-OR mux.
  logic [WIDTH-1:0] w_term_a [c_DEPTH];
  logic [WIDTH-1:0] w_term_b [c_DEPTH];

  logic [WIDTH-1:0] w_out_a;
  logic [WIDTH-1:0] w_out_b;

  genvar gi;
  generate
    for (gi = 0; gi < c_DEPTH; gi++) begin : g_word
      logic [WIDTH-1:0] r_q;

      assign w_sel[gi]   = (address   == ADDR_WIDTH'(gi));
      assign w_sel_b[gi] = (address_b == ADDR_WIDTH'(gi));

      // Word register with load mux; reset dominates the write enable.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_q <= '0;
        end else if (load && w_sel[gi]) begin
          r_q <= in;
        end
      end

      assign w_term_a[gi] = w_sel[gi]   ? r_q : '0;
      assign w_term_b[gi] = w_sel_b[gi] ? r_q : '0;
    end
  endgenerate

  // Read port A: OR-reduce the one-hot gated words (no bypass from in).
  always_comb begin
    w_out_a = '0;
    for (int j = 0; j < c_DEPTH; j++) begin
      w_out_a = w_out_a | w_term_a[j];
    end
  end

  // Read port B: same structure, independent address.
  always_comb begin
    w_out_b = '0;
    for (int j = 0; j < c_DEPTH; j++) begin
      w_out_b = w_out_b | w_term_b[j];
    end
  end

  assign out   = w_out_a;
  assign out_b = w_out_b;

endmodule
`default_nettype wire

// File: tb/tb__ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb__ram
//  Description : Self-checking bench for _ram: directed vectors on the
//                16x8 configuration plus a reference-model sweep of the
//                1x2 and 8x64 configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb__ram;

  logic clk;
  int   n_tests = 0;
  int   n_fail  = 0;

  // ---------------- main DUT: WIDTH=16, ADDR_WIDTH=3 ----------------
  logic        reset, load;
  logic [15:0] in, out, out_b;
  logic [2:0]  address, address_b;

  _ram #(.WIDTH(16), .ADDR_WIDTH(3)) u_dut (
    .clk(clk), .reset(reset), .in(in), .load(load),
    .address(address), .address_b(address_b), .out(out), .out_b(out_b)
  );

  // ---------------- WIDTH=1, ADDR_WIDTH=1 ----------------
  logic       s_reset, s_load;
  logic [0:0] s_in, s_out, s_out_b, s_addr, s_addr_b;

  _ram #(.WIDTH(1), .ADDR_WIDTH(1)) u_small (
    .clk(clk), .reset(s_reset), .in(s_in), .load(s_load),
    .address(s_addr), .address_b(s_addr_b), .out(s_out), .out_b(s_out_b)
  );

  // ---------------- WIDTH=8, ADDR_WIDTH=6 ----------------
  logic       b_reset, b_load;
  logic [7:0] b_in, b_out, b_out_b;
  logic [5:0] b_addr, b_addr_b;

  _ram #(.WIDTH(8), .ADDR_WIDTH(6)) u_big (
    .clk(clk), .reset(b_reset), .in(b_in), .load(b_load),
    .address(b_addr), .address_b(b_addr_b), .out(b_out), .out_b(b_out_b)
  );

  // Reference contents
  logic [15:0] m16 [8];
  logic [0:0]  m1  [2];
  logic [7:0]  m8  [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_main(input string tag);
    for (int a = 0; a < 8; a++) begin
      address   = 3'(a);
      address_b = 3'(7 - a);
      #1;
      check_val($sformatf("%s_a%0d", tag, a), {48'b0, out},   {48'b0, m16[a]});
      check_val($sformatf("%s_b%0d", tag, 7 - a), {48'b0, out_b}, {48'b0, m16[7 - a]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load = 1'b0; in = '0; address = '0; address_b = '0;
    s_reset = 1'b1; s_load = 1'b0; s_in = '0; s_addr = '0; s_addr_b = '0;
    b_reset = 1'b1; b_load = 1'b0; b_in = '0; b_addr = '0; b_addr_b = '0;
    tick();
    reset = 1'b0; s_reset = 1'b0; b_reset = 1'b0;
    for (int i = 0; i < 8; i++) m16[i] = 16'h0000;
    for (int i = 0; i < 2; i++) m1[i] = 1'b0;
    for (int i = 0; i < 64; i++) m8[i] = 8'h00;
    sweep_main("reset_init");

    // Reset clear after filling every word with ones
    load = 1'b1; in = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      tick();
    end
    load = 1'b0;
    address = 3'd6; address_b = 3'd2; #1;
    check_val("fill_a6", {48'b0, out},   64'hFFFF);
    check_val("fill_b2", {48'b0, out_b}, 64'hFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_main("reset_clear");

    // Write all with load held high for 8 consecutive edges
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      in = 16'hA500 + 16'(i);
      tick();
      m16[i] = 16'hA500 + 16'(i);
    end
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        address = 3'(a); address_b = 3'(b); #1;
        check_val($sformatf("wr_a%0d_b%0d_a", a, b), {48'b0, out},   {48'b0, 16'hA500 + 16'(a)});
        check_val($sformatf("wr_a%0d_b%0d_b", a, b), {48'b0, out_b}, {48'b0, 16'hA500 + 16'(b)});
      end
    end

    // Read-during-write on the same address
    address = 3'd3; in = 16'h1111; load = 1'b1;
    tick();
    address_b = 3'd3; in = 16'h2222; load = 1'b1; #1;
    check_val("rdw_pre_a", {48'b0, out},   64'h1111);
    check_val("rdw_pre_b", {48'b0, out_b}, 64'h1111);
    tick();
    load = 1'b0;
    check_val("rdw_post_a", {48'b0, out},   64'h2222);
    check_val("rdw_post_b", {48'b0, out_b}, 64'h2222);
    m16[3] = 16'h2222;

    // load low: nothing changes over 10 edges
    in = 16'hDEAD; load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      address = 3'(i % 8);
      tick();
    end
    sweep_main("hold");

    // Reset wins over a coincident write
    reset = 1'b1; load = 1'b1; address = 3'd5; in = 16'h7777;
    tick();
    reset = 1'b0; load = 1'b0;
    for (int i = 0; i < 8; i++) m16[i] = 16'h0000;
    sweep_main("rst_prio");
    load = 1'b1; address = 3'd5; in = 16'h7777;
    tick();
    load = 1'b0;
    m16[5] = 16'h7777;
    sweep_main("post_rst_wr");

    // Randomised sweep of the 1x2 and 8x64 configurations
    for (int cyc = 0; cyc < 1000; cyc++) begin
      s_reset = ((cyc % 97) == 50) || ($urandom_range(0, 99) == 0);
      b_reset = ((cyc % 89) == 40) || ($urandom_range(0, 99) == 0);
      s_load = 1'($urandom_range(0, 1)); s_in = 1'($urandom);
      s_addr = 1'($urandom); s_addr_b = 1'($urandom);
      b_load = 1'($urandom_range(0, 1)); b_in = 8'($urandom);
      b_addr = 6'($urandom); b_addr_b = 6'($urandom);
      #1;
      check_val($sformatf("w1_a_c%0d", cyc), {63'b0, s_out},   {63'b0, m1[s_addr]});
      check_val($sformatf("w1_b_c%0d", cyc), {63'b0, s_out_b}, {63'b0, m1[s_addr_b]});
      check_val($sformatf("w8_a_c%0d", cyc), {56'b0, b_out},   {56'b0, m8[b_addr]});
      check_val($sformatf("w8_b_c%0d", cyc), {56'b0, b_out_b}, {56'b0, m8[b_addr_b]});
      if (s_reset) begin
        for (int i = 0; i < 2; i++) m1[i] = 1'b0;
      end else if (s_load) begin
        m1[s_addr] = s_in;
      end
      if (b_reset) begin
        for (int i = 0; i < 64; i++) m8[i] = 8'h00;
      end else if (b_load) begin
        m8[b_addr] = b_in;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/_ram.md
Name: _ram

Overview:
- Parametrised word-addressable RAM. Sequential successor to the combinational gate library.
- Generalises the Hack RAM8/RAM64 family to any width and depth, and adds a second independent read port.
- Used as the backing store for the register file and data memory of the Hack-style CPU.
- Storage is an array of WIDTH-bit registers: one write port, two asynchronous read ports.

Parameters:
WIDTH, 16, bits per word; legal values >= 1
ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH words; legal values >= 1

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  synchronous, active-high; clears every word
in  input  WIDTH  write data
load  input  1  write enable
address  input  ADDR_WIDTH  write address and port-A read address
address_b  input  ADDR_WIDTH  port-B read address
out  output  WIDTH  contents of word[address]
out_b  output  WIDTH  contents of word[address_b]

Behaviour:
- Reset is synchronous, active-high, sampled on the rising edge of clk. No asynchronous reset path.
- State: DEPTH words, word[0..DEPTH-1], each WIDTH bits.
- Reset edge:
  - All words become 0; out and out_b read 0 from that edge onward until a write.
  - Reset has priority over load: a coincident write is discarded.
  - Reset mid-sequence (after any writes) clears everything; no partial retention.
- Before the first reset edge, word contents and outputs are undefined (X in simulation); benches must not check them.
- Write: on a rising edge with reset=0 and load=1, word[address] <= in. No other word changes.
- load=0: all words hold.
- Read ports are combinational from stored state:
  - out = word[address]; out_b = word[address_b]. Zero-cycle latency w.r.t. address change.
- Read-during-write, same cycle, same address:
  - out / out_b show the OLD value until the edge and the NEW value immediately after it.
  - No write-through bypass from in to out.
- address == address_b is legal; both ports then show identical data.
- All address values 0..DEPTH-1 are valid. No out-of-range case exists, because DEPTH is an exact power of two.
- Width rules: in and word contents are stored unmodified. No sign handling, no arithmetic.
- No handshake: a write completes in exactly one clock. load may be held high across consecutive cycles to write a different address every cycle.
- X or Z on load or address during a write edge: behaviour undefined; the bench must keep them driven.
- Structure:
  - Each word is a WIDTH-bit register with load mux: next = reset ? 0 : (load & sel[i]) ? in : word[i].
  - sel is a one-hot decode of address (DMux-tree style).
  - Each read port is a DEPTH:1 WIDTH-bit mux.
  - Built with generate loops so any WIDTH/ADDR_WIDTH elaborates.

Test Plan:
- Reset clear (WIDTH=16, ADDR_WIDTH=3): write 16'hFFFF to all 8 words, assert reset 1 cycle → out=0 and out_b=0 for every address sweep 0..7.
- Write/read all: write word i = 16'hA500+i for i=0..7 with load held high 8 consecutive cycles, then sweep address 0..7 and address_b 7..0 → out=16'hA500+address, out_b=16'hA500+address_b, every combination correct.
- Read-during-write: word[3]=16'h1111; drive address=3, in=16'h2222, load=1 → out=16'h1111 before the edge, 16'h2222 after it; out_b at address_b=3 tracks identically.
- Load low hold: load=0, in=16'hDEAD, cycle through all addresses for 10 cycles → no word changes from prior contents.
- Reset priority: reset=1 and load=1, address=5, in=16'h7777 on the same edge → word[5]=0 and all words 0; the next edge with reset=0, load=1 writes 16'h7777 to word[5] only.
- Parameter sweep: instantiate WIDTH=1/ADDR_WIDTH=1 and WIDTH=8/ADDR_WIDTH=6 → random write/read scoreboard over 1000 cycles with periodic resets; zero mismatches against the reference model.
